clock_set_ctrl: RTL and testbench
=================================

// Module: clock_set_ctrl
// PURPOSE
//  Time-set controller sequencing the HH:MM BCD clock datapath and the 4-digit 7-seg display.
//  Two debounced buttons (mode, up) step through RUN -> SET_H -> SET_M -> COMMIT.
//  Gates clock counting, edits hours/minutes with auto-repeat, blinks the edited pair.
//  Issues a one-cycle load of the new time. Sits between the board buttons, Clock and Disp7Seg.
// PARAMETERS
//  BLINK_DIV   25_000_000  cycles per blink phase toggle (100 MHz -> 2 Hz blink)
//  REPEAT_DLY  50_000_000  cycles btn_up must be held before auto-repeat starts
//  REPEAT_DIV  10_000_000  cycles between auto-repeat increments
// PORTS
//  clk          in   1  system clock, single domain
//  reset        in   1  asynchronous, active-low
//  btn_mode     in   1  debounced level, asynchronous to clk
//  btn_up       in   1  debounced level, asynchronous to clk
//  cur_hora_d   in   4  running time, hour tens (BCD)
//  cur_hora_u   in   4  running time, hour units
//  cur_min_d    in   4  running time, minute tens
//  cur_min_u    in   4  running time, minute units
//  run_en       out  1  1 = Clock may count; 0 = frozen
//  load         out  1  one-cycle strobe: Clock loads set_* this cycle
//  set_hora_d/set_hora_u/set_min_d/set_min_u  out  4 each  edited time (BCD), valid with load
//  disp_d3..disp_d0   out  4 each  digits to Disp7Seg (d3 = hour tens)
//  blank        out  4  per-digit blank mask, bit3 = d3; 1 = digit dark
//  mode         out  2  00 RUN, 01 SET_H, 10 SET_M, 11 COMMIT
// BEHAVIOUR
//  Reset (reset=0, async): state RUN, run_en=1, load=0, blank=0, mode=00.
//   Edit regs 00:00, all counters 0, synchronizer flops 0.
//  Input path: 2-FF synchronizer per button, then rising-edge detect.
//   Edge pulse appears 3 clk after input rises; held level gives one pulse.
//  Simultaneous mode and up pulse in the same cycle: mode wins, increment dropped.
//  RUN: run_en=1, disp_* = cur_*, blank=0. mode pulse -> SET_H.
//   Same edge captures cur_* into edit regs and drives run_en=0 from the next cycle.
//   Captured hours >23 or any digit >9 -> hours 00.
//   Captured minutes >59 or any digit >9 -> minutes 00.
//  SET_H: up pulse or repeat tick -> hours +1 BCD (x9 -> (x+1)0, 23 -> 00). Minutes untouched.
//   mode pulse -> SET_M.
//  SET_M: up/repeat -> minutes +1 BCD (59 -> 00). No carry into hours.
//   mode pulse -> COMMIT.
//  COMMIT: exactly one cycle.
//   load=1, set_* = edit regs, run_en=0.
//   Next state RUN; run_en=1 from the following cycle.
//  Outside COMMIT: load=0, set_* hold edit regs.
//  In SET_H/SET_M: disp_* = edit regs.
//  Auto-repeat: active only in SET_H/SET_M while synced btn_up=1.
//   After the edge increment, a hold counter runs; at REPEAT_DLY it increments.
//   Then it increments every REPEAT_DIV cycles.
//   Counter clears on release or on any state change.
//  Blink: phase counter wraps at BLINK_DIV-1 and toggles blink_ph.
//   Entering SET_H/SET_M, or any increment, clears counter and blink_ph (visible).
//   SET_H: blank = {blink_ph,blink_ph,2'b00}. SET_M: blank = {2'b00,blink_ph,blink_ph}.
//   RUN/COMMIT: blank = 0.
//  Reset mid-edit: returns to RUN, no load, edits discarded.
//  Counter widths: $clog2 of the respective parameter.
//  Outputs: run_en/load/mode registered; disp_*/blank combinational from registered state.
// TESTING (BLINK_DIV=8, REPEAT_DLY=20, REPEAT_DIV=4 in bench)
//  Reset with cur=12:34 -> run_en=1, load=0, blank=0, disp=1,2,3,4, mode=00.
//  mode pulse, cur=12:34 -> mode=01, run_en=0, disp=12:34.
//   Blank toggles bits[3:2] every 8 clk, starting visible.
//  SET_H at 23, one up pulse -> hours 00. SET_M at 59, up -> minutes 00, hours unchanged.
//  Hold btn_up 50 clk in SET_M from 00 -> edge +1.
//   Then +1 at 20 clk after the edge increment, then every 4 clk; release stops immediately.
//  Full sequence 12:34 -> 14:35 -> mode x3.
//   COMMIT gives load=1 for exactly 1 clk with set=1,4,3,5; run_en=1 next clk.
//  mode and up rise same clk in SET_H -> state SET_M, hours unchanged.
//   Reset asserted in SET_M -> RUN, no load pulse ever.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: time-set sequencer between the board buttons, the HH:MM
// BCD clock datapath and the 4-digit 7-seg display driver.
// RUN -> SET_H -> SET_M -> COMMIT (one cycle, load strobe) -> RUN.
module clock_set_ctrl #(
  parameter int BLINK_DIV  = 25_000_000,
  parameter int REPEAT_DLY = 50_000_000,
  parameter int REPEAT_DIV = 10_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic [3:0] cur_hora_d,
  input  logic [3:0] cur_hora_u,
  input  logic [3:0] cur_min_d,
  input  logic [3:0] cur_min_u,
  output logic       run_en,
  output logic       load,
  output logic [3:0] set_hora_d,
  output logic [3:0] set_hora_u,
  output logic [3:0] set_min_d,
  output logic [3:0] set_min_u,
  output logic [3:0] disp_d3,
  output logic [3:0] disp_d2,
  output logic [3:0] disp_d1,
  output logic [3:0] disp_d0,
  output logic [3:0] blank,
  output logic [1:0] mode
);

  localparam int RMAX = (REPEAT_DLY > REPEAT_DIV) ? REPEAT_DLY : REPEAT_DIV;
  localparam int BW   = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam int RW   = (RMAX > 2) ? $clog2(RMAX) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [RW-1:0] DLY_LAST   = RW'(REPEAT_DLY - 1);
  localparam logic [RW-1:0] DIV_LAST   = RW'(REPEAT_DIV - 1);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    SET_H  = 2'b01,
    SET_M  = 2'b10,
    COMMIT = 2'b11
  } state_e;

  state_e          state_q;
  logic            run_en_q, load_q;
  logic [3:0]      eh10_q, eh1_q, em10_q, em1_q;
  logic [3:0]      eh10_d, eh1_d, em10_d, em1_d;
  logic [2:0]      mode_sync_q, up_sync_q;   // [1:0] synchronizer, [2] edge-detect delay
  logic [RW-1:0]   rpt_cnt_q;
  logic            rpt_ph_q;                 // 0: waiting initial delay, 1: repeating
  logic [BW-1:0]   blink_cnt_q;
  logic            blink_ph_q;

  logic mode_pls, up_pls, up_lvl, editing, rpt_tick, inc, hr_ok, mn_ok;

  assign mode_pls = mode_sync_q[1] & ~mode_sync_q[2];
  assign up_pls   = up_sync_q[1] & ~up_sync_q[2];
  assign up_lvl   = up_sync_q[1];
  assign editing  = (state_q == SET_H) || (state_q == SET_M);
  assign rpt_tick = editing && up_lvl && !up_pls &&
                    (rpt_cnt_q == (rpt_ph_q ? DIV_LAST : DLY_LAST));
  // A mode pulse in the same cycle swallows any increment.
  assign inc      = editing && !mode_pls && (up_pls || rpt_tick);

  // Captured running time must be a legal HH:MM, otherwise that pair starts at 00.
  assign hr_ok = ((cur_hora_d < 4'd2) && (cur_hora_u <= 4'd9)) ||
                 ((cur_hora_d == 4'd2) && (cur_hora_u <= 4'd3));
  assign mn_ok = (cur_min_d <= 4'd5) && (cur_min_u <= 4'd9);

  // BCD +1 for both pairs; hours wrap 23->00, minutes wrap 59->00 without carry.
  always_comb begin
    eh10_d = eh10_q;
    eh1_d  = eh1_q;
    em10_d = em10_q;
    em1_d  = em1_q;
    if (eh10_q == 4'd2 && eh1_q == 4'd3) begin
      eh10_d = 4'd0;
      eh1_d  = 4'd0;
    end else if (eh1_q == 4'd9) begin
      eh10_d = eh10_q + 4'd1;
      eh1_d  = 4'd0;
    end else begin
      eh1_d  = eh1_q + 4'd1;
    end
    if (em1_q == 4'd9) begin
      em1_d  = 4'd0;
      em10_d = (em10_q == 4'd5) ? 4'd0 : em10_q + 4'd1;
    end else begin
      em1_d  = em1_q + 4'd1;
    end
  end

  // Button synchronizers and edge-detect delay stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_sync_q <= '0;
      up_sync_q   <= '0;
    end else begin
      mode_sync_q <= {mode_sync_q[1:0], btn_mode};
      up_sync_q   <= {up_sync_q[1:0], btn_up};
    end
  end

  // Mode FSM with registered run_en/load and the edit registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= RUN;
      run_en_q <= 1'b1;
      load_q   <= 1'b0;
      eh10_q   <= '0;
      eh1_q    <= '0;
      em10_q   <= '0;
      em1_q    <= '0;
    end else begin
      load_q <= 1'b0;
      unique case (state_q)
        RUN: begin
          run_en_q <= 1'b1;
          if (mode_pls) begin
            state_q  <= SET_H;
            run_en_q <= 1'b0;
            eh10_q   <= hr_ok ? cur_hora_d : 4'd0;
            eh1_q    <= hr_ok ? cur_hora_u : 4'd0;
            em10_q   <= mn_ok ? cur_min_d  : 4'd0;
            em1_q    <= mn_ok ? cur_min_u  : 4'd0;
          end
        end
        SET_H: begin
          if (mode_pls) begin
            state_q <= SET_M;
          end else if (inc) begin
            eh10_q <= eh10_d;
            eh1_q  <= eh1_d;
          end
        end
        SET_M: begin
          if (mode_pls) begin
            state_q <= COMMIT;
            load_q  <= 1'b1;
          end else if (inc) begin
            em10_q <= em10_d;
            em1_q  <= em1_d;
          end
        end
        COMMIT: begin
          state_q  <= RUN;
          run_en_q <= 1'b1;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  // Auto-repeat hold counter: initial delay, then a fixed repeat period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rpt_cnt_q <= '0;
      rpt_ph_q  <= 1'b0;
    end else if (!editing || !up_lvl || mode_pls || up_pls) begin
      rpt_cnt_q <= '0;
      rpt_ph_q  <= 1'b0;
    end else if (rpt_tick) begin
      rpt_cnt_q <= '0;
      rpt_ph_q  <= 1'b1;
    end else begin
      rpt_cnt_q <= rpt_cnt_q + 1'b1;
    end
  end

  // Blink phase generator; restarts visible on entry and on every increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
    end else if (!editing || mode_pls || inc) begin
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_q <= '0;
      blink_ph_q  <= ~blink_ph_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  // Display mux and blank mask from registered state.
  always_comb begin
    {disp_d3, disp_d2, disp_d1, disp_d0} = {cur_hora_d, cur_hora_u, cur_min_d, cur_min_u};
    blank = 4'b0000;
    if (state_q != RUN)
      {disp_d3, disp_d2, disp_d1, disp_d0} = {eh10_q, eh1_q, em10_q, em1_q};
    if (state_q == SET_H) blank = {blink_ph_q, blink_ph_q, 2'b00};
    if (state_q == SET_M) blank = {2'b00, blink_ph_q, blink_ph_q};
  end

  assign run_en     = run_en_q;
  assign load       = load_q;
  assign mode       = state_q;
  assign set_hora_d = eh10_q;
  assign set_hora_u = eh1_q;
  assign set_min_d  = em10_q;
  assign set_min_u  = em1_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with short blink/repeat periods.
module tb_clock_set_ctrl;

  logic clk = 1'b0, reset = 1'b0, btn_mode = 1'b0, btn_up = 1'b0;
  logic [15:0] cur = 16'h1234;
  logic run_en, load;
  logic [3:0] set_hora_d, set_hora_u, set_min_d, set_min_u;
  logic [3:0] disp_d3, disp_d2, disp_d1, disp_d0, blank;
  logic [1:0] mode;
  logic [15:0] disp, setv;
  int n_tests = 0, n_fail = 0, load_cnt = 0;

  assign disp = {disp_d3, disp_d2, disp_d1, disp_d0};
  assign setv = {set_hora_d, set_hora_u, set_min_d, set_min_u};

  clock_set_ctrl #(.BLINK_DIV(8), .REPEAT_DLY(20), .REPEAT_DIV(4)) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_up(btn_up),
    .cur_hora_d(cur[15:12]), .cur_hora_u(cur[11:8]),
    .cur_min_d(cur[7:4]), .cur_min_u(cur[3:0]),
    .run_en(run_en), .load(load),
    .set_hora_d(set_hora_d), .set_hora_u(set_hora_u),
    .set_min_d(set_min_d), .set_min_u(set_min_u),
    .disp_d3(disp_d3), .disp_d2(disp_d2), .disp_d1(disp_d1), .disp_d0(disp_d0),
    .blank(blank), .mode(mode)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (load === 1'b1) load_cnt++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Press held 3 clk (action lands on the 3rd edge), then released 3 clk.
  task automatic press_mode;
    btn_mode = 1'b1;
    repeat (3) tick();
    btn_mode = 1'b0;
    repeat (3) tick();
  endtask

  task automatic press_up;
    btn_up = 1'b1;
    repeat (3) tick();
    btn_up = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset;
    cur = 16'h1234;
    reset = 1'b0;
    repeat (2) tick();
    n_tests++; if (run_en !== 1'b1) begin n_fail++; $display("FAIL reset_run_en: got %b exp 1", run_en); end
    n_tests++; if (load !== 1'b0) begin n_fail++; $display("FAIL reset_load: got %b exp 0", load); end
    n_tests++; if (blank !== 4'b0000) begin n_fail++; $display("FAIL reset_blank: got %b exp 0000", blank); end
    n_tests++; if (disp !== 16'h1234) begin n_fail++; $display("FAIL reset_disp: got %h exp 1234", disp); end
    n_tests++; if (mode !== 2'b00) begin n_fail++; $display("FAIL reset_mode: got %b exp 00", mode); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_enter_set;
    press_mode();
    n_tests++; if (mode !== 2'b01) begin n_fail++; $display("FAIL enter_mode: got %b exp 01", mode); end
    n_tests++; if (run_en !== 1'b0) begin n_fail++; $display("FAIL enter_run_en: got %b exp 0", run_en); end
    n_tests++; if (disp !== 16'h1234) begin n_fail++; $display("FAIL enter_disp: got %h exp 1234", disp); end
    n_tests++; if (blank !== 4'b0000) begin n_fail++; $display("FAIL blink_start: got %b exp 0000", blank); end
    repeat (5) tick();
    n_tests++; if (blank !== 4'b1100) begin n_fail++; $display("FAIL blink_dark: got %b exp 1100", blank); end
    repeat (7) tick();
    n_tests++; if (blank !== 4'b1100) begin n_fail++; $display("FAIL blink_dark_end: got %b exp 1100", blank); end
    tick();
    n_tests++; if (blank !== 4'b0000) begin n_fail++; $display("FAIL blink_lit: got %b exp 0000", blank); end
  endtask

  task automatic test_hour_wrap;
    repeat (11) press_up();
    n_tests++; if (disp !== 16'h2334) begin n_fail++; $display("FAIL hour_to_23: got %h exp 2334", disp); end
    press_up();
    n_tests++; if (disp !== 16'h0034) begin n_fail++; $display("FAIL hour_wrap: got %h exp 0034", disp); end
    n_tests++; if (blank !== 4'b0000) begin n_fail++; $display("FAIL hour_inc_blank: got %b exp 0000", blank); end
  endtask

  task automatic test_simultaneous;
    btn_mode = 1'b1; btn_up = 1'b1;
    repeat (3) tick();
    btn_mode = 1'b0; btn_up = 1'b0;
    repeat (3) tick();
    n_tests++; if (mode !== 2'b10) begin n_fail++; $display("FAIL simul_mode: got %b exp 10", mode); end
    n_tests++; if (disp !== 16'h0034) begin n_fail++; $display("FAIL simul_disp: got %h exp 0034", disp); end
  endtask

  task automatic test_min_wrap;
    repeat (25) press_up();
    n_tests++; if (disp !== 16'h0059) begin n_fail++; $display("FAIL min_to_59: got %h exp 0059", disp); end
    press_up();
    n_tests++; if (disp !== 16'h0000) begin n_fail++; $display("FAIL min_wrap: got %h exp 0000", disp); end
    repeat (5) tick();
    n_tests++; if (blank !== 4'b0011) begin n_fail++; $display("FAIL min_blink: got %b exp 0011", blank); end
  endtask

  task automatic test_repeat;
    btn_up = 1'b1;
    repeat (3) tick();
    n_tests++; if (disp !== 16'h0001) begin n_fail++; $display("FAIL rpt_edge: got %h exp 0001", disp); end
    repeat (19) tick();
    n_tests++; if (disp !== 16'h0001) begin n_fail++; $display("FAIL rpt_before_dly: got %h exp 0001", disp); end
    tick();
    n_tests++; if (disp !== 16'h0002) begin n_fail++; $display("FAIL rpt_at_dly: got %h exp 0002", disp); end
    repeat (3) tick();
    n_tests++; if (disp !== 16'h0002) begin n_fail++; $display("FAIL rpt_before_div: got %h exp 0002", disp); end
    tick();
    n_tests++; if (disp !== 16'h0003) begin n_fail++; $display("FAIL rpt_at_div: got %h exp 0003", disp); end
    repeat (23) tick();
    n_tests++; if (disp !== 16'h0008) begin n_fail++; $display("FAIL rpt_held: got %h exp 0008", disp); end
    btn_up = 1'b0;
    repeat (10) tick();
    n_tests++; if (disp !== 16'h0009) begin n_fail++; $display("FAIL rpt_release: got %h exp 0009", disp); end
  endtask

  task automatic test_reset_mid_edit;
    reset = 1'b0;
    #1;
    n_tests++; if (mode !== 2'b00) begin n_fail++; $display("FAIL midrst_mode: got %b exp 00", mode); end
    n_tests++; if (run_en !== 1'b1) begin n_fail++; $display("FAIL midrst_run_en: got %b exp 1", run_en); end
    n_tests++; if (disp !== 16'h1234) begin n_fail++; $display("FAIL midrst_disp: got %h exp 1234", disp); end
    repeat (2) tick();
    reset = 1'b1;
    repeat (2) tick();
    n_tests++; if (load_cnt !== 0) begin n_fail++; $display("FAIL midrst_no_load: got %0d exp 0", load_cnt); end
  endtask

  task automatic test_commit;
    press_mode();
    repeat (2) press_up();
    n_tests++; if (disp !== 16'h1434) begin n_fail++; $display("FAIL seq_hours: got %h exp 1434", disp); end
    press_mode();
    press_up();
    n_tests++; if (disp !== 16'h1435) begin n_fail++; $display("FAIL seq_minutes: got %h exp 1435", disp); end
    btn_mode = 1'b1;
    repeat (3) tick();
    n_tests++; if (load !== 1'b1) begin n_fail++; $display("FAIL commit_load: got %b exp 1", load); end
    n_tests++; if (setv !== 16'h1435) begin n_fail++; $display("FAIL commit_set: got %h exp 1435", setv); end
    n_tests++; if (run_en !== 1'b0) begin n_fail++; $display("FAIL commit_run_en: got %b exp 0", run_en); end
    n_tests++; if (mode !== 2'b11) begin n_fail++; $display("FAIL commit_mode: got %b exp 11", mode); end
    tick();
    n_tests++; if (load !== 1'b0) begin n_fail++; $display("FAIL post_load: got %b exp 0", load); end
    n_tests++; if (run_en !== 1'b1) begin n_fail++; $display("FAIL post_run_en: got %b exp 1", run_en); end
    n_tests++; if (mode !== 2'b00) begin n_fail++; $display("FAIL post_mode: got %b exp 00", mode); end
    btn_mode = 1'b0;
    repeat (3) tick();
    n_tests++; if (load_cnt !== 1) begin n_fail++; $display("FAIL load_once: got %0d exp 1", load_cnt); end
  endtask

  task automatic test_capture_invalid;
    cur = 16'h2567;
    press_mode();
    n_tests++; if (disp !== 16'h0000) begin n_fail++; $display("FAIL cap_both_bad: got %h exp 0000", disp); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    cur = 16'h095A;
    tick();
    press_mode();
    n_tests++; if (disp !== 16'h0900) begin n_fail++; $display("FAIL cap_min_bad: got %h exp 0900", disp); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    cur = 16'h2A41;
    tick();
    press_mode();
    n_tests++; if (disp !== 16'h0041) begin n_fail++; $display("FAIL cap_hour_bad: got %h exp 0041", disp); end
  endtask

  initial begin
    test_reset();
    test_enter_set();
    test_hour_wrap();
    test_simultaneous();
    test_min_wrap();
    test_repeat();
    test_reset_mid_edit();
    test_commit();
    test_capture_invalid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
